// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, default width.
package alu_sequencer_pkg;

    localparam int ALU_DW = 8;

    typedef enum logic [2:0] {
        kADD = 3'd0,
        kOR  = 3'd1,
        kXOR = 3'd2,
        kAND = 3'd3,
        kLT  = 3'd4,
        kEQ  = 3'd5,
        kSLL = 3'd6,
        kSRL = 3'd7
    } op_mne;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_M_ADD = 3'd2,
        S_M_SHL = 3'd3,
        S_M_SHR = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Sequences an external combinational ALU for one requester: single ops take one
// ALU cycle, MUL runs as a shift-add loop using only ADD/SLL/SRL.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a request, ALU driven with idle ADD 0,0
// S_EXEC  | single op on the ALU, result captured at the next edge
// S_M_ADD | acc += (mplier[0] ? mcand : 0)
// S_M_SHL | mcand <<= 1
// S_M_SHR | mplier >>= 1, iteration count, loop or finish
// S_DONE  | response held until the consumer takes it
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DW         = ALU_DW,
    parameter int MUL_ITERS  = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic          ReqMul,
    input  logic [2:0]    ReqOp,
    input  logic [DW-1:0] ReqA,
    input  logic [DW-1:0] ReqB,
    output logic          RspValid,
    input  logic          RspReady,
    output logic [DW-1:0] RspData,
    output logic          RspZero,
    output logic [2:0]    AluOp,
    output logic [DW-1:0] AluA,
    output logic [DW-1:0] AluB,
    input  logic [DW-1:0] AluOut,
    input  logic          AluZero
);

    localparam int IW = $clog2(MUL_ITERS + 1);

    seq_state_e    state_q, state_d;
    op_mne         op_q;
    logic [DW-1:0] mcand_q;
    logic [DW-1:0] mplier_q;
    logic [DW-1:0] acc_q;
    logic [IW-1:0] iter_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_zero_q;
    logic          accept;
    logic          mul_last;

    assign accept   = ReqValid && (state_q == S_IDLE);
    // Only meaningful in S_M_SHR, where AluZero reflects the shifted multiplier.
    assign mul_last = (EARLY_EXIT && AluZero) || (iter_q == IW'(MUL_ITERS - 1));

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; unused encodings fall back to idle.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = accept ? (ReqMul ? S_M_ADD : S_EXEC) : S_IDLE;
            S_EXEC:  state_d = S_DONE;
            S_M_ADD: state_d = S_M_SHL;
            S_M_SHL: state_d = S_M_SHR;
            S_M_SHR: state_d = mul_last ? S_DONE : S_M_ADD;
            S_DONE:  state_d = RspReady ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: handshake and ALU operand mux per state.
    always_comb begin
        ReqReady = 1'b0;
        AluOp    = kADD;
        AluA     = '0;
        AluB     = '0;
        case (state_q)
            S_IDLE:  ReqReady = 1'b1;
            S_EXEC: begin
                AluOp = op_q;
                AluA  = mcand_q;
                AluB  = mplier_q;
            end
            S_M_ADD: begin
                AluOp = kADD;
                AluA  = acc_q;
                AluB  = mplier_q[0] ? mcand_q : '0;
            end
            S_M_SHL: begin
                AluOp = kSLL;
                AluA  = mcand_q;
                AluB  = DW'(1);
            end
            S_M_SHR: begin
                AluOp = kSRL;
                AluA  = mplier_q;
                AluB  = DW'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers: operand capture, MUL accumulation, response hold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q       <= kADD;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= op_mne'(ReqOp);
                        mcand_q  <= ReqA;
                        mplier_q <= ReqB;
                        acc_q    <= '0;
                        iter_q   <= '0;
                    end
                end
                S_EXEC: begin
                    rsp_data_q <= AluOut;
                    rsp_zero_q <= AluZero;
                end
                S_M_ADD: acc_q   <= AluOut;
                S_M_SHL: mcand_q <= AluOut;
                S_M_SHR: begin
                    mplier_q <= AluOut;
                    iter_q   <= iter_q + IW'(1);
                    // acc is final here: the last ADD happened two cycles ago.
                    if (mul_last) begin
                        rsp_data_q <= acc_q;
                        rsp_zero_q <= (acc_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign RspValid = (state_q == S_DONE);
    assign RspData  = rsp_data_q;
    assign RspZero  = rsp_zero_q;

endmodule
